// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared stall, exception and state definitions for pipe_ctrl
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Bit order: [0]=pc [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
  localparam logic [5:0] STALL_NONE = {6{NOSTOP}};
  localparam logic [5:0] STALL_ID   = {{3{NOSTOP}}, {3{STOP}}};
  localparam logic [5:0] STALL_EX   = {{2{NOSTOP}}, {4{STOP}}};
  localparam logic [5:0] STALL_MEM  = {NOSTOP, {5{STOP}}};
  localparam logic [5:0] STALL_ALL  = {6{STOP}};

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic [5:0] run_stall(input logic id, input logic ex, input logic mem);
    if (mem)     return STALL_MEM;
    else if (ex) return STALL_EX;
    else if (id) return STALL_ID;
    else         return STALL_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_bus_wdog.sv
// ============================================================================
// bus_wdog : counts consecutive bus-wait cycles and pulses on expiry
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module bus_wdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_clr,
  output logic o_expire,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // Expiry is combinational so the owner can redirect on the same edge the pulse registers.
  assign o_expire  = i_req && !i_clr && (r_cnt == LAST);
  assign o_timeout = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= o_expire;
      if (!i_req || i_clr || o_expire) r_cnt <= '0;
      else                             r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : stall vector, exception/ERET flush sequencing and bus watchdog
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          TIMEOUT    = 255,
  parameter int          CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_timeout,
  output logic        busy_hold
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pend_code;
  logic [31:0] r_pend_epc;
  logic [31:0] r_new_pc;
  logic        r_flush;
  logic [5:0]  w_stall;
  logic        w_latch;
  logic        w_busy;
  logic        w_expire;
  logic        w_timeout;
  logic [31:0] w_code;
  logic [31:0] w_epc;
  logic [31:0] w_target;

  bus_wdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_req     (stallreq_mem),
    .i_clr     (r_state == ST_FLUSH),
    .o_expire  (w_expire),
    .o_timeout (w_timeout)
  );

  always_comb begin
    w_next  = r_state;
    w_stall = STALL_NONE;
    w_latch = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_stall = run_stall(stallreq_id, stallreq_ex, stallreq_mem);
        if (excepttype_i != EXC_NONE) begin
          w_latch = 1'b1;
          w_next  = stallreq_mem ? ST_HOLD : ST_FLUSH;
        end
      end
      ST_HOLD: begin
        w_busy  = 1'b1;
        w_stall = stallreq_mem ? STALL_MEM : STALL_ALL;
        if (!stallreq_mem) w_next = ST_FLUSH;
      end
      ST_FLUSH: w_next = ST_RUN;
      default:  w_next = ST_RUN;
    endcase
    if (w_expire) w_next = ST_FLUSH;
  end

  // In RUN the exception is consumed on the same edge it is latched, so look through the latch.
  assign w_code   = (r_state == ST_RUN) ? excepttype_i : r_pend_code;
  assign w_epc    = (r_state == ST_RUN) ? cp0_epc_i    : r_pend_epc;
  assign w_target = (!w_expire && w_code == EXC_ERET) ? w_epc : EXC_VECTOR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pend_code <= EXC_NONE;
      r_pend_epc  <= '0;
      r_new_pc    <= '0;
      r_flush     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_flush <= (w_next == ST_FLUSH);
      if (w_next == ST_FLUSH) r_new_pc <= w_target;
      if (w_latch) begin
        r_pend_code <= excepttype_i;
        r_pend_epc  <= cp0_epc_i;
      end else if (r_state == ST_FLUSH) begin
        r_pend_code <= EXC_NONE;
      end
    end
  end

  assign stall       = rst ? STALL_NONE : w_stall;
  assign flush       = r_flush;
  assign new_pc      = r_new_pc;
  assign bus_timeout = w_timeout;
  assign busy_hold   = w_busy;

endmodule

`default_nettype wire
